// File: rtl/tt_bist_harness.sv
// On-chip stimulus/response BIST harness: LFSR vector source, MISR response compactor, golden-signature check.
// Optional expected-response mismatch counter is enabled by defining BIST_LOOPBACK_CHECK_EN.
module tt_bist_harness #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      NUM_VECTORS = 256,
   parameter int unsigned      LATENCY     = 1,
   parameter logic [WIDTH-1:0] LFSR_TAPS   = 8'h1D,
   parameter logic [WIDTH-1:0] LFSR_SEED   = 8'h01,
   parameter logic [WIDTH-1:0] EXP_SIG     = 8'h00
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   output logic [WIDTH-1:0] stim_out,
   input  logic [WIDTH-1:0] resp_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [15:0]      vec_count
`ifdef BIST_LOOPBACK_CHECK_EN
   ,
   output logic [15:0]      mismatch_count
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_e;

   // An all-zero Galois register never leaves zero, so a zero seed is replaced by 1.
   localparam logic [WIDTH-1:0] SEED       = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
   localparam logic [15:0]      LAST_VEC   = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]       DRAIN_INIT = 4'(LATENCY - 1);

   function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
      return (v << 1) ^ (v[WIDTH-1] ? LFSR_TAPS : '0);
   endfunction

   state_e           state_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] stim_q;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic [15:0]      vec_q;
   logic [3:0]       drain_q;
   logic             busy_q, done_q, pass_q;
   logic             pass_d;
   logic             issue, cap_valid, capture;

`ifdef BIST_LOOPBACK_CHECK_EN
   logic [WIDTH-1:0] exp_q;
   logic [15:0]      mm_q, mm_d;
`endif

   assign issue   = (state_q == S_DRIVE) && ena;
   assign capture = cap_valid && ena;

   if (LATENCY == 0) begin : g_direct
      assign cap_valid = issue;
   end else begin : g_pipe
      logic [LATENCY-1:0] pipe_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pipe_q <= '0;
         end else if (!ena) begin
            pipe_q <= '0;
         end else begin
            pipe_q[0] <= issue;
            for (int i = 1; i < int'(LATENCY); i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      assign cap_valid = pipe_q[LATENCY-1];
   end

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      sig_d = sig_q;
      if (capture) begin
         sig_d = galois_step(sig_q) ^ resp_in;
      end
`ifdef BIST_LOOPBACK_CHECK_EN
      mm_d = mm_q;
      if (capture && (resp_in != exp_q) && (mm_q != 16'hFFFF)) begin
         mm_d = mm_q + 16'd1;
      end
      pass_d = (sig_d == EXP_SIG) && (mm_d == 16'd0);
`else
      pass_d = (sig_d == EXP_SIG);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         stim_q  <= '0;
         sig_q   <= '0;
         vec_q   <= '0;
         drain_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef BIST_LOOPBACK_CHECK_EN
         exp_q   <= SEED;
         mm_q    <= '0;
`endif
      end else if (!ena) begin
         // Abort: signature and vec_count are left intact for debug.
         state_q <= S_IDLE;
         stim_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         sig_q <= sig_d;
`ifdef BIST_LOOPBACK_CHECK_EN
         mm_q <= mm_d;
         if (capture) begin
            exp_q <= galois_step(exp_q);
         end
`endif
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_DRIVE;
                  stim_q  <= SEED;
                  lfsr_q  <= galois_step(SEED);
                  sig_q   <= '0;
                  vec_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
`ifdef BIST_LOOPBACK_CHECK_EN
                  exp_q   <= SEED;
                  mm_q    <= '0;
`endif
               end
            end
            S_DRIVE: begin
               vec_q <= vec_q + 16'd1;
               if (vec_q == LAST_VEC) begin
                  stim_q <= '0;
                  if (LATENCY == 0) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= pass_d;
                  end else begin
                     state_q <= S_DRAIN;
                     drain_q <= DRAIN_INIT;
                  end
               end else begin
                  stim_q <= lfsr_q;
                  lfsr_q <= galois_step(lfsr_q);
               end
            end
            S_DRAIN: begin
               // The final in-flight response is absorbed on the same edge that enters DONE.
               if (drain_q == 4'd0) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= pass_d;
               end else begin
                  drain_q <= drain_q - 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stim_out  = stim_q;
   assign signature = sig_q;
   assign vec_count = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
`ifdef BIST_LOOPBACK_CHECK_EN
   assign mismatch_count = mm_q;
`endif

endmodule

// File: tb/tb_tt_bist_harness.sv
// Directed self-checking bench for tt_bist_harness: four instances covering tied-zero response,
// a wrong golden signature, and loopback at LATENCY 0 and 3.
module tb_tt_bist_harness;

   logic clk, rst_n, ena, start;
   logic flip_en;

   logic [7:0]  stim_m, resp_m, sig_m;
   logic        busy_m, done_m, pass_m;
   logic [15:0] vec_m;

   logic [7:0]  stim_a, resp_a, sig_a;
   logic        busy_a, done_a, pass_a;
   logic [15:0] vec_a;

   logic [7:0]  stim_z, resp_z, sig_z;
   logic        busy_z, done_z, pass_z;
   logic [15:0] vec_z;

   logic [7:0]  stim_t, resp_t, sig_t;
   logic        busy_t, done_t, pass_t;
   logic [15:0] vec_t;
   logic [7:0]  d1, d2, d3;

`ifdef BIST_LOOPBACK_CHECK_EN
   logic [15:0] mm_m, mm_a, mm_z, mm_t;
`endif

   int n_cmp = 0;
   int n_err = 0;

   tt_bist_harness u_main (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .stim_out(stim_m), .resp_in(resp_m), .busy(busy_m), .done(done_m),
      .pass(pass_m), .signature(sig_m), .vec_count(vec_m)
`ifdef BIST_LOOPBACK_CHECK_EN
      , .mismatch_count(mm_m)
`endif
   );

   tt_bist_harness #(.EXP_SIG(8'h5A)) u_sig5a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .stim_out(stim_a), .resp_in(resp_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .signature(sig_a), .vec_count(vec_a)
`ifdef BIST_LOOPBACK_CHECK_EN
      , .mismatch_count(mm_a)
`endif
   );

   tt_bist_harness #(.LATENCY(0)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .stim_out(stim_z), .resp_in(resp_z), .busy(busy_z), .done(done_z),
      .pass(pass_z), .signature(sig_z), .vec_count(vec_z)
`ifdef BIST_LOOPBACK_CHECK_EN
      , .mismatch_count(mm_z)
`endif
   );

   tt_bist_harness #(.LATENCY(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
      .stim_out(stim_t), .resp_in(resp_t), .busy(busy_t), .done(done_t),
      .pass(pass_t), .signature(sig_t), .vec_count(vec_t)
`ifdef BIST_LOOPBACK_CHECK_EN
      , .mismatch_count(mm_t)
`endif
   );

   // Loopback DUT models: a wire with optional bit-0 faults on vectors 5 and 9, and a 3-stage pipe.
   assign resp_z = stim_z ^ {7'b0, flip_en && busy_z && (vec_z == 16'd4 || vec_z == 16'd8)};
   assign resp_t = d3;

   always @(posedge clk) begin
      d1 <= stim_t;
      d2 <= d1;
      d3 <= d2;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] step(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
   endfunction

   // Signature of a clean loopback run: 256 LFSR vectors from seed 1 folded into the MISR.
   function automatic logic [7:0] model_sig();
      logic [7:0] l, s;
      l = 8'h01;
      s = 8'h00;
      for (int i = 0; i < 256; i++) begin
         s = step(s) ^ l;
         l = step(l);
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_stim [10];
      logic [7:0] msig;
      int cyc, busy_cnt, at_m, at_z, at_t, guard;

      exp_stim = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
      msig = model_sig();
      rst_n = 1'b0; ena = 1'b0; start = 1'b0; flip_en = 1'b0;
      resp_m = 8'h00; resp_a = 8'h00;
      d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;

      #13;
      check("rst_stim",  stim_m, 8'h00);
      check("rst_sig",   sig_m,  8'h00);
      check("rst_vec",   vec_m,  16'd0);
      check("rst_busy",  busy_m, 1'b0);
      check("rst_done",  done_m, 1'b0);
      check("rst_pass",  pass_m, 1'b0);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();

      // Run 1: full run on all instances; cycle 0 is the first DRIVE cycle.
      pulse_start();
      busy_cnt = 0; at_m = -1; at_z = -1; at_t = -1;
      for (cyc = 0; cyc < 400; cyc++) begin
         if (cyc < 10) check($sformatf("stim_%0d", cyc), stim_m, exp_stim[cyc]);
         if (busy_m) busy_cnt++;
         if (at_m < 0 && done_m) at_m = cyc;
         if (at_z < 0 && done_z) at_z = cyc;
         if (at_t < 0 && done_t) at_t = cyc;
         if (done_m && done_z && done_t) break;
         tick();
      end
      check("busy_cycles",  busy_cnt, 257);
      check("done_at_l1",   at_m, 257);
      check("done_at_l0",   at_z, 256);
      check("done_at_l3",   at_t, 259);
      check("vec_done",     vec_m, 16'd256);
      check("sig_zero",     sig_m, 8'h00);
      check("pass_zero",    pass_m, 1'b1);
      check("stim_idle",    stim_m, 8'h00);
      check("done_5a",      done_a, 1'b1);
      check("pass_5a",      pass_a, 1'b0);
      check("sig_l0",       sig_z, msig);
      check("sig_l3",       sig_t, msig);
      check("pass_l0",      pass_z, (msig == 8'h00));
`ifdef BIST_LOOPBACK_CHECK_EN
      check("mm_l0_clean",  mm_z, 16'd0);
      check("mm_l3_clean",  mm_t, 16'd0);
`endif

      // Restart from DONE clears the signature and starts the vector stream over.
      pulse_start();
      check("rs_busy", busy_m, 1'b1);
      check("rs_done", done_m, 1'b0);
      check("rs_vec",  vec_m,  16'd0);
      check("rs_stim", stim_m, 8'h01);
      check("rs_sig3", sig_t,  8'h00);
      repeat (50) tick();
      check("vec_50",  vec_m, 16'd50);
      pulse_start();
      check("drive_start_ign", vec_m, 16'd51);
      repeat (49) tick();
      check("vec_100", vec_m, 16'd100);

      // Abort with ena low, then a start while disabled is ignored.
      ena = 1'b0;
      tick();
      check("ab_busy", busy_m, 1'b0);
      check("ab_done", done_m, 1'b0);
      check("ab_stim", stim_m, 8'h00);
      check("ab_vec",  vec_m,  16'd100);
      check("ab_pass", pass_m, 1'b0);
      pulse_start();
      check("ena0_start_busy", busy_m, 1'b0);
      check("ena0_start_vec",  vec_m,  16'd100);

      // Run 2: full clean run after abort; LATENCY 0 instance sees two faulted responses.
      ena = 1'b1;
      flip_en = 1'b1;
      tick();
      pulse_start();
      guard = 0;
      while (vec_m != 16'd256 && guard < 400) begin
         tick();
         guard++;
      end
      check("r2_reach_256", guard, 256);
      check("r2_drain_busy", busy_m, 1'b1);
      check("r2_done_l0",    done_z, 1'b1);
`ifdef BIST_LOOPBACK_CHECK_EN
      check("mm_l0_flip",    mm_z,   16'd2);
      check("pass_l0_flip",  pass_z, 1'b0);
`endif
      pulse_start();
      flip_en = 1'b0;
      check("drain_start_done", done_m, 1'b1);
      check("drain_start_vec",  vec_m,  16'd256);
      check("r2_sig",           sig_m,  8'h00);
      check("r2_pass",          pass_m, 1'b1);

      // Asynchronous reset in the middle of DRIVE, sampled before the next clock edge.
      pulse_start();
      repeat (10) tick();
      check("mid_busy", busy_m, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_stim", stim_m, 8'h00);
      check("arst_busy", busy_m, 1'b0);
      check("arst_done", done_m, 1'b0);
      check("arst_vec",  vec_m,  16'd0);
      check("arst_sig3", sig_t,  8'h00);
      check("arst_pass", pass_m, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
